reorder_fifo: RTL

In-order reorder FIFO between the dispatch stage and the commit stage. Each cycle it accepts at most one reorder record from dispatch (PC, renamed destination, branch/store/CSR flags) and presents the oldest record to commit. Commit retires that record with a pop. A flush empties the queue in one cycle on mispredict or trap. It provides the `reOrder_fifo_full` back-pressure that gates dispatch.

---
 rtl/reorder_fifo.sv | 116 +++++++++++
 1 files changed

// File: rtl/reorder_fifo.sv
// -----------------------------------------------------------------------------
// reorder_fifo
//
// In-order reorder queue between dispatch and commit. Dispatch enqueues at
// most one record per cycle; commit sees the oldest record on commit_info and
// retires it with commit_pop. A flush discards every resident entry in one
// cycle (mispredict / trap recovery). reOrder_fifo_full back-pressures
// dispatch.
//
// Parameters
//   DW : record width (64 PC + 5+RB rename + 3 flags = 76 with RB=4)
//   AW : pointer index width, depth DP = 2**AW
//
// Ports
//   CLK                : clock, all state changes on the rising edge
//   RST                : synchronous active-high reset, highest priority
//   dispat_info        : record to enqueue
//   reOrder_fifo_push  : enqueue request
//   reOrder_fifo_full  : occupancy == DP (pointer-derived, registered)
//   reOrder_fifo_empty : occupancy == 0  (pointer-derived, registered)
//   commit_info        : record at the head (stale content when empty)
//   commit_pop         : retire the head record
//   flush              : discard all entries, beats push and pop
//   reOrder_fifo_cnt   : occupancy 0..DP
//
// Build option
//   REORDER_FIFO_FULL_PASS_EN : when defined, a push that arrives while the
//   queue is full is still accepted if commit pops in the same cycle (the
//   slot being vacated is reused). When undefined such a push is dropped.
// -----------------------------------------------------------------------------
module reorder_fifo #(
   parameter int DW = 76,
   parameter int AW = 2
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic [DW-1:0] dispat_info,
   input  logic          reOrder_fifo_push,
   output logic          reOrder_fifo_full,
   output logic          reOrder_fifo_empty,
   output logic [DW-1:0] commit_info,
   input  logic          commit_pop,
   input  logic          flush,
   output logic [AW:0]   reOrder_fifo_cnt
);

   localparam int DP = 1 << AW;

   // Storage: plain array, data is never reset.
   logic [DW-1:0] r_mem [DP];

   // Pointers carry one extra wrap bit above the index.
   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;

   logic [AW-1:0] w_wr_idx;
   logic [AW-1:0] w_rd_idx;
   logic          w_full;
   logic          w_empty;
   logic          w_push_ok;
   logic          w_pop_ok;
   logic          w_wr_en;

   assign w_wr_idx = r_wr_ptr[AW-1:0];
   assign w_rd_idx = r_rd_ptr[AW-1:0];

   // Status is decoded from registered pointers only.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (w_wr_idx == w_rd_idx) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

`ifdef REORDER_FIFO_FULL_PASS_EN
   // While full, the head slot being retired this cycle is the slot the
   // write pointer addresses, so a simultaneous push can reuse it.
   assign w_push_ok = reOrder_fifo_push & (~w_full | commit_pop);
`else
   assign w_push_ok = reOrder_fifo_push & ~w_full;
`endif

   assign w_pop_ok = commit_pop & ~w_empty;

   // Reset and flush both suppress the array write so a discarded record
   // never lands in storage.
   assign w_wr_en = w_push_ok & ~flush & ~RST;

   always_ff @(posedge CLK) begin
      if (w_wr_en) begin
         r_mem[w_wr_idx] <= dispat_info;
      end
   end

   // Pointer update: reset > flush > push/pop.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (flush) begin
         r_rd_ptr <= r_wr_ptr;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
         end
      end
   end

   // Head read is combinational from registered storage; no fall-through
   // from dispat_info when empty.
   assign commit_info        = r_mem[w_rd_idx];
   assign reOrder_fifo_full  = w_full;
   assign reOrder_fifo_empty = w_empty;
   // Modulo 2**(AW+1) difference gives 0..DP directly.
   assign reOrder_fifo_cnt   = r_wr_ptr - r_rd_ptr;

endmodule
